spram_resp: RTL and testbench
=============================

# spram_resp

Synthesizable single-port RAM responder: 32 words × 8 bits behind an ena/wea/addra/dina/douta port. It answers the `ram_rw` access generator from the memory side, as a drop-in, simulator-visible alternative to the vendor block-memory core. It adds:
- a configurable read pipeline,
- a selectable write-collision mode,
- a read-valid strobe,
- an optional post-reset clear sequencer.

## Interface
Parameters:
- `READ_LATENCY`, default 1: cycles from access to `douta`/`rvalid`. Legal values are 1 or 2.
- `WRITE_MODE`, default 0: `douta` behaviour on a write.
  - 0 = READ_FIRST
  - 1 = WRITE_FIRST
  - 2 = NO_CHANGE

Ports:
- `clka`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: reset, asynchronous and active-low.
- `ena`, input, 1: access enable.
- `wea`, input, 1: write enable; qualified by `ena`.
- `addra`, input, 5: word address.
- `dina`, input, 8: write data.
- `douta`, output, 8: read data, registered.
- `rvalid`, output, 1: `douta` carries a new result this cycle.
- `busy`, output, 1: responder not accepting accesses (clear in progress).

## Operation
- An access is accepted on an edge where `ena`=1 and `busy`=0.
  - `ena`=0, or `busy`=1: no memory change, no `rvalid`, `douta` holds.
- Read (`wea`=0): `mem[addra]` appears on `douta` after `READ_LATENCY` cycles, with `rvalid`=1.
- Write (`wea`=1): `mem[addra]`←`dina` at the accepting edge. `douta` depends on `WRITE_MODE`:
  - 0: old `mem[addra]` is returned, `rvalid`=1.
  - 1: `dina` is returned, `rvalid`=1.
  - 2: `douta` holds its previous value, `rvalid`=0.
- Back-to-back accesses are allowed every cycle; the pipeline is fully throughput-1.
- Read following a write to the same address on the next edge: returns the new data in every mode.
- Address wrap: 5-bit `addra` only, so there are no out-of-range addresses.
- Reset (`rst`=0, any time, including mid-access or mid-clear):
  - `douta`=8'h00, `rvalid`=0, pipeline stages cleared.
  - In-flight reads are discarded.
  - Memory contents are unchanged except as described under Configuration.
- `busy` reset value: 1 with the clear feature, 0 without.

## Timing
- `READ_LATENCY`=1: access accepted at edge N → `douta`/`rvalid` update at edge N+1.
- `READ_LATENCY`=2: extra output register → update at edge N+2. Intermediate stage values are not visible.
- `rvalid` is a one-cycle pulse per qualifying access; consecutive accesses give consecutive pulses.
- Writes take effect at edge N; no write latency is visible to later reads.
- Reset release: first acceptable access is at the first edge after `rst` rises when the clear feature is out; otherwise see Configuration.

## Configuration
- Macro: `SPRAM_RESP_CLEAR_EN`.
- Defined:
  - Clear FSM with states IDLE → CLEAR → READY.
  - Reset forces IDLE, `busy`=1. First edge after reset release: IDLE→CLEAR, clear address = 0.
  - CLEAR: writes 8'h00 to `mem[clr_addr]` each edge and increments `clr_addr`. After writing address 31 it moves to READY; `busy` falls at that same edge (32 cycles in CLEAR).
  - Accesses with `busy`=1 are ignored (no write, no `rvalid`).
  - Reset asserted during CLEAR restarts the sequence from address 0.
  - READY is terminal until the next reset.
- Undefined:
  - No FSM; `busy` is tied 0.
  - Memory is uninitialized (X in simulation); reset does not touch contents.

## Structure
- Package `spram_pkg`:
  - `SPRAM_DEPTH`=32, `SPRAM_AW`=5, `SPRAM_DW`=8.
  - Write-mode constants `WM_READ_FIRST`/`WM_WRITE_FIRST`/`WM_NO_CHANGE`.
  - Clear-FSM state typedef `clr_state_t`.
- Sub-module `spram_out_pipe`:
  - parameterized by `READ_LATENCY`;
  - carries data plus valid through 1 or 2 async-reset registers;
  - owns the reset values of `douta`/`rvalid`.
- Memory array, write logic and clear FSM stay in `spram_resp`.

## Test plan
- Write then read (mode 0, latency 1): write 8'hA5 to address 3, then read address 3 → `douta`=8'hA5 with `rvalid` one cycle after the read edge.
- Collision modes: `mem[7]`=8'h11, then write 8'h22 to address 7.
  - Mode 0 → `douta`=8'h11.
  - Mode 1 → 8'h22.
  - Mode 2 → `douta` unchanged, `rvalid`=0.
- Latency 2 streaming: 32 consecutive reads of addresses 0..31 after writing `addr`^8'h5A → 32 consecutive `rvalid` pulses, in order, starting 2 cycles after the first read, with no gaps.
- Reset mid-stream: assert `rst`=0 while a latency-2 read is in flight → `douta`=0 and `rvalid`=0 immediately; no late `rvalid` after release.
- `SPRAM_RESP_CLEAR_EN`:
  - After release, `busy`=1 for exactly 32 cycles.
  - A write issued during `busy` is dropped.
  - Afterwards, reading all addresses returns 8'h00.
  - Reset at clear address 10 → a full 32-cycle clear restarts.
- `ena`=0 with `wea`=1 for several cycles → memory unchanged, `douta` holds, no `rvalid`.

Source files
------------

// File: rtl/spram_pkg.sv
// spram_pkg: shared geometry, write-collision mode codes and clear-FSM
// state type for the spram_resp single-port RAM responder.
package spram_pkg;

  localparam int SPRAM_DEPTH = 32;
  localparam int SPRAM_AW    = 5;
  localparam int SPRAM_DW    = 8;

  // Last word of the array; the clear sequencer stops after writing it.
  localparam logic [SPRAM_AW-1:0] SPRAM_LAST_ADDR = 5'd31;

  // douta behaviour on a write access.
  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Post-reset clear sequencer states.
  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_READY = 2'd2
  } clr_state_t;

endpackage

// File: rtl/spram_resp_if.sv
// spram_resp_if: the ena/wea/addra/dina/douta port of the RAM plus its
// rvalid strobe and busy flag. The access generator uses the master
// modport, the RAM responder the slave modport.
interface spram_resp_if;

  logic                             ena;
  logic                             wea;
  logic [spram_pkg::SPRAM_AW-1:0]   addra;
  logic [spram_pkg::SPRAM_DW-1:0]   dina;
  logic [spram_pkg::SPRAM_DW-1:0]   douta;
  logic                             rvalid;
  logic                             busy;

  modport master (
    output ena, wea, addra, dina,
    input  douta, rvalid, busy
  );

  modport slave (
    input  ena, wea, addra, dina,
    output douta, rvalid, busy
  );

endinterface

// File: rtl/spram_out_pipe.sv
// spram_out_pipe: read-data output registers. Carries data plus a valid
// flag through READ_LATENCY (1 or 2) async-reset stages. Data registers
// only load on a valid beat so douta holds between results; reset clears
// every stage so in-flight results are dropped.
module spram_out_pipe
  import spram_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  input  logic [SPRAM_DW-1:0] i_data,
  output logic [SPRAM_DW-1:0] o_data,
  output logic                o_valid
);

  logic                w_stage_valid;
  logic [SPRAM_DW-1:0] w_stage_data;

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic                r_s1_valid;
      logic [SPRAM_DW-1:0] r_s1_data;

      // extra hidden stage used only for the two-cycle read latency
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_s1_valid <= 1'b0;
          r_s1_data  <= {SPRAM_DW{1'b0}};
        end else begin
          r_s1_valid <= i_valid;
          if (i_valid) begin
            r_s1_data <= i_data;
          end
        end
      end

      assign w_stage_valid = r_s1_valid;
      assign w_stage_data  = r_s1_data;
    end else begin : g_lat1
      assign w_stage_valid = i_valid;
      assign w_stage_data  = i_data;
    end
  endgenerate

  // visible output register: pulse rvalid, hold douta between results
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
      o_data  <= {SPRAM_DW{1'b0}};
    end else begin
      o_valid <= w_stage_valid;
      if (w_stage_valid) begin
        o_data <= w_stage_data;
      end
    end
  end

endmodule

// File: rtl/spram_resp.sv
// spram_resp: 32x8 single-port RAM responder with configurable read
// latency, write-collision mode and a read-valid strobe.
// Optional feature macro: SPRAM_RESP_CLEAR_EN -- when defined, a clear
// sequencer zero-fills the array after every reset and holds busy high
// until the last word is written.
module spram_resp
  import spram_pkg::*;
#(
  parameter int READ_LATENCY = 1,
  parameter int WRITE_MODE   = WM_READ_FIRST
) (
  input  logic        clka,
  input  logic        rst,
  spram_resp_if.slave bus
);

  logic [SPRAM_DW-1:0] r_mem [SPRAM_DEPTH];

  logic                w_busy;
  logic                w_acc;
  logic                w_req_valid;
  logic [SPRAM_DW-1:0] w_req_data;
  logic                r_cap_valid;
  logic [SPRAM_DW-1:0] r_cap_data;

`ifdef SPRAM_RESP_CLEAR_EN
  clr_state_t          r_clr_state;
  clr_state_t          w_clr_state_nxt;
  logic [SPRAM_AW-1:0] r_clr_addr;
  logic [SPRAM_AW-1:0] w_clr_addr_nxt;
  logic                w_clr_we;

  // clear sequencer state and address registers
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      r_clr_state <= CLR_IDLE;
      r_clr_addr  <= {SPRAM_AW{1'b0}};
    end else begin
      r_clr_state <= w_clr_state_nxt;
      r_clr_addr  <= w_clr_addr_nxt;
    end
  end

  // clear sequencer next state: one zero write per edge, addresses 0..31
  always_comb begin
    w_clr_state_nxt = r_clr_state;
    w_clr_addr_nxt  = r_clr_addr;
    w_clr_we        = 1'b0;
    case (r_clr_state)
      CLR_IDLE: begin
        w_clr_state_nxt = CLR_CLEAR;
        w_clr_addr_nxt  = {SPRAM_AW{1'b0}};
      end
      CLR_CLEAR: begin
        w_clr_we = 1'b1;
        if (r_clr_addr == SPRAM_LAST_ADDR) begin
          w_clr_state_nxt = CLR_READY;
        end else begin
          w_clr_addr_nxt = r_clr_addr + 5'd1;
        end
      end
      CLR_READY: begin
        w_clr_state_nxt = CLR_READY;
      end
      default: begin
        w_clr_state_nxt = CLR_IDLE;
      end
    endcase
  end

  // busy falls on the same edge that writes the last word
  assign w_busy = (r_clr_state != CLR_READY);
`else
  assign w_busy = 1'b0;
`endif

  assign bus.busy = w_busy;
  assign w_acc    = bus.ena & ~w_busy;

  // array write port: accepted host writes, else clear-sequencer zero fill
  always_ff @(posedge clka) begin
    if (w_acc && bus.wea) begin
      r_mem[bus.addra] <= bus.dina;
    end
`ifdef SPRAM_RESP_CLEAR_EN
    else if (w_clr_we) begin
      r_mem[r_clr_addr] <= {SPRAM_DW{1'b0}};
    end
`endif
  end

  // request decode: what an accepted access returns and whether it strobes
  always_comb begin
    w_req_valid = 1'b0;
    w_req_data  = r_mem[bus.addra];
    if (w_acc) begin
      if (bus.wea) begin
        case (WRITE_MODE)
          WM_WRITE_FIRST: begin
            w_req_valid = 1'b1;
            w_req_data  = bus.dina;
          end
          WM_NO_CHANGE: begin
            w_req_valid = 1'b0;
          end
          default: begin
            w_req_valid = 1'b1;
          end
        endcase
      end else begin
        w_req_valid = 1'b1;
      end
    end else begin
      w_req_valid = 1'b0;
    end
  end

  // capture the pre-write array word (or dina) at the accepting edge
  always_ff @(posedge clka or negedge rst) begin
    if (!rst) begin
      r_cap_valid <= 1'b0;
      r_cap_data  <= {SPRAM_DW{1'b0}};
    end else begin
      r_cap_valid <= w_req_valid;
      if (w_req_valid) begin
        r_cap_data <= w_req_data;
      end
    end
  end

  spram_out_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_out_pipe (
    .i_clk   (clka),
    .i_rst_n (rst),
    .i_valid (r_cap_valid),
    .i_data  (r_cap_data),
    .o_data  (bus.douta),
    .o_valid (bus.rvalid)
  );

endmodule

// File: tb/tb_spram_resp.sv
// tb_spram_resp: directed bench for spram_resp. Four instances share one
// stimulus stream: read-first/lat1, write-first/lat1, no-change/lat1 and
// read-first/lat2. Build with SPRAM_RESP_CLEAR_EN to exercise the clear
// sequencer as well.
module tb_spram_resp;
  import spram_pkg::*;

  logic       clka = 1'b0;
  logic       rst;
  logic       ena;
  logic       wea;
  logic [4:0] addra;
  logic [7:0] dina;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clka = ~clka;

  spram_resp_if if0 ();
  spram_resp_if if1 ();
  spram_resp_if if2 ();
  spram_resp_if if3 ();

  assign if0.ena = ena; assign if0.wea = wea; assign if0.addra = addra; assign if0.dina = dina;
  assign if1.ena = ena; assign if1.wea = wea; assign if1.addra = addra; assign if1.dina = dina;
  assign if2.ena = ena; assign if2.wea = wea; assign if2.addra = addra; assign if2.dina = dina;
  assign if3.ena = ena; assign if3.wea = wea; assign if3.addra = addra; assign if3.dina = dina;

  spram_resp #(.READ_LATENCY(1), .WRITE_MODE(WM_READ_FIRST))  u_rf1 (.clka(clka), .rst(rst), .bus(if0));
  spram_resp #(.READ_LATENCY(1), .WRITE_MODE(WM_WRITE_FIRST)) u_wf1 (.clka(clka), .rst(rst), .bus(if1));
  spram_resp #(.READ_LATENCY(1), .WRITE_MODE(WM_NO_CHANGE))   u_nc1 (.clka(clka), .rst(rst), .bus(if2));
  spram_resp #(.READ_LATENCY(2), .WRITE_MODE(WM_READ_FIRST))  u_rf2 (.clka(clka), .rst(rst), .bus(if3));

  task automatic cyc();
    @(posedge clka);
    #1;
  endtask

  task automatic idle(input int n);
    ena = 1'b0;
    wea = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic test_reset();
    logic exp_busy;
`ifdef SPRAM_RESP_CLEAR_EN
    exp_busy = 1'b1;
`else
    exp_busy = 1'b0;
`endif
    rst = 1'b0; ena = 1'b0; wea = 1'b0; addra = 5'd0; dina = 8'h00;
    repeat (3) cyc();
    n_checks++; if (if0.douta !== 8'h00) begin n_fail++; $display("FAIL reset_douta_rf1: got %h want 00", if0.douta); end
    n_checks++; if (if1.douta !== 8'h00) begin n_fail++; $display("FAIL reset_douta_wf1: got %h want 00", if1.douta); end
    n_checks++; if (if2.douta !== 8'h00) begin n_fail++; $display("FAIL reset_douta_nc1: got %h want 00", if2.douta); end
    n_checks++; if (if3.douta !== 8'h00) begin n_fail++; $display("FAIL reset_douta_rf2: got %h want 00", if3.douta); end
    n_checks++; if (if0.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_rf1: got %b want 0", if0.rvalid); end
    n_checks++; if (if3.rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid_rf2: got %b want 0", if3.rvalid); end
    n_checks++; if (if0.busy !== exp_busy) begin n_fail++; $display("FAIL reset_busy: got %b want %b", if0.busy, exp_busy); end
    rst = 1'b1;
  endtask

`ifdef SPRAM_RESP_CLEAR_EN
  task automatic test_clear();
    int   n;
    logic saw_rv;
    n = 0;
    saw_rv = 1'b0;
    // a write held on the bus for the whole clear must be dropped
    ena = 1'b1; wea = 1'b1; addra = 5'd0; dina = 8'hEE;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (if0.rvalid) saw_rv = 1'b1;
      if (if0.busy) n++;
      else break;
    end
    ena = 1'b0; wea = 1'b0;
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d want 32", n); end
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy_timeout: got %b want 0", if0.busy); end
    n_checks++; if (saw_rv !== 1'b0) begin n_fail++; $display("FAIL clear_write_dropped_rvalid: got %b want 0", saw_rv); end
    for (int a = 0; a < 32; a++) begin
      ena = 1'b1; wea = 1'b0; addra = 5'(a);
      cyc();
      ena = 1'b0;
      cyc();
      n_checks++; if (if0.douta !== 8'h00 || if0.rvalid !== 1'b1) begin
        n_fail++; $display("FAIL clear_read_a%0d: got %h/%b want 00/1", a, if0.douta, if0.rvalid);
      end
    end
  endtask

  task automatic test_clear_restart();
    int n;
    rst = 1'b0; cyc(); rst = 1'b1;
    // IDLE edge plus ten clear writes leaves the sequencer at address 10
    repeat (11) cyc();
    rst = 1'b0; cyc(); rst = 1'b1;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      cyc();
      if (if0.busy) n++;
      else break;
    end
    n_checks++; if (n !== 32) begin n_fail++; $display("FAIL clear_restart_cycles: got %0d want 32", n); end
  endtask
`endif

  task automatic test_write_read();
    idle(2);
    ena = 1'b1; wea = 1'b1; addra = 5'd3; dina = 8'hA5;
    cyc();
    wea = 1'b0;
    cyc();
    ena = 1'b0;
    cyc();
    n_checks++; if (if0.douta !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_douta: got %h want a5", if0.douta); end
    n_checks++; if (if0.rvalid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_rvalid: got %b want 1", if0.rvalid); end
    cyc();
    n_checks++; if (if0.rvalid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_pulse: got %b want 0", if0.rvalid); end
    n_checks++; if (if0.douta !== 8'hA5) begin n_fail++; $display("FAIL wr_rd_hold: got %h want a5", if0.douta); end
  endtask

  task automatic test_collision();
    idle(3);
    ena = 1'b1; wea = 1'b1; addra = 5'd7; dina = 8'h11;
    cyc();
    idle(3);
    ena = 1'b1; wea = 1'b1; addra = 5'd7; dina = 8'h22;
    cyc();
    ena = 1'b0; wea = 1'b0;
    cyc();
    n_checks++; if (if0.douta !== 8'h11 || if0.rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_read_first: got %h/%b want 11/1", if0.douta, if0.rvalid); end
    n_checks++; if (if1.douta !== 8'h22 || if1.rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_write_first: got %h/%b want 22/1", if1.douta, if1.rvalid); end
    n_checks++; if (if2.douta !== 8'hA5 || if2.rvalid !== 1'b0) begin n_fail++; $display("FAIL coll_no_change: got %h/%b want a5/0", if2.douta, if2.rvalid); end
    cyc();
    n_checks++; if (if3.douta !== 8'h11 || if3.rvalid !== 1'b1) begin n_fail++; $display("FAIL coll_read_first_lat2: got %h/%b want 11/1", if3.douta, if3.rvalid); end
    // write then read the same word on the very next edge
    idle(2);
    ena = 1'b1; wea = 1'b1; addra = 5'd7; dina = 8'h33;
    cyc();
    wea = 1'b0;
    cyc();
    ena = 1'b0;
    cyc();
    n_checks++; if (if0.douta !== 8'h33 || if0.rvalid !== 1'b1) begin n_fail++; $display("FAIL raw_rf1: got %h/%b want 33/1", if0.douta, if0.rvalid); end
    n_checks++; if (if1.douta !== 8'h33 || if1.rvalid !== 1'b1) begin n_fail++; $display("FAIL raw_wf1: got %h/%b want 33/1", if1.douta, if1.rvalid); end
    n_checks++; if (if2.douta !== 8'h33 || if2.rvalid !== 1'b1) begin n_fail++; $display("FAIL raw_nc1: got %h/%b want 33/1", if2.douta, if2.rvalid); end
  endtask

  task automatic test_ena_low();
    idle(3);
    ena = 1'b0; wea = 1'b1; addra = 5'd7; dina = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if ({if0.rvalid, if1.rvalid, if2.rvalid, if3.rvalid} !== 4'b0000) begin
        n_fail++; $display("FAIL ena_low_rvalid_c%0d: got %b%b%b%b want 0000", i, if0.rvalid, if1.rvalid, if2.rvalid, if3.rvalid);
      end
      n_checks++; if (if0.douta !== 8'h33 || if3.douta !== 8'h33) begin
        n_fail++; $display("FAIL ena_low_hold_c%0d: got %h/%h want 33/33", i, if0.douta, if3.douta);
      end
    end
    ena = 1'b1; wea = 1'b0; addra = 5'd7;
    cyc();
    ena = 1'b0;
    cyc();
    n_checks++; if (if0.douta !== 8'h33 || if0.rvalid !== 1'b1) begin n_fail++; $display("FAIL ena_low_mem: got %h/%b want 33/1", if0.douta, if0.rvalid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic       ev;
    idle(2);
    for (int a = 0; a < 32; a++) begin
      e = 8'(a);
      ena = 1'b1; wea = 1'b1; addra = 5'(a); dina = e ^ 8'h5A;
      cyc();
    end
    idle(3);
    for (int c = 0; c < 36; c++) begin
      if (c < 32) begin
        ena = 1'b1; wea = 1'b0; addra = 5'(c);
      end else begin
        ena = 1'b0;
      end
      cyc();
      // latency 2: read accepted at edge c appears after edge c+2
      ev = (c >= 2 && c <= 33);
      e  = 8'(c - 2);
      e  = e ^ 8'h5A;
      n_checks++; if (if3.rvalid !== ev) begin n_fail++; $display("FAIL stream2_rvalid_c%0d: got %b want %b", c, if3.rvalid, ev); end
      if (ev) begin
        n_checks++; if (if3.douta !== e) begin n_fail++; $display("FAIL stream2_douta_c%0d: got %h want %h", c, if3.douta, e); end
      end
      ev = (c >= 1 && c <= 32);
      e  = 8'(c - 1);
      e  = e ^ 8'h5A;
      n_checks++; if (if0.rvalid !== ev) begin n_fail++; $display("FAIL stream1_rvalid_c%0d: got %b want %b", c, if0.rvalid, ev); end
      if (ev) begin
        n_checks++; if (if0.douta !== e) begin n_fail++; $display("FAIL stream1_douta_c%0d: got %h want %h", c, if0.douta, e); end
      end
    end
  endtask

  task automatic test_reset_midstream();
    logic [7:0] exp_mem;
    int         n;
    idle(3);
    ena = 1'b1; wea = 1'b0; addra = 5'd4;
    cyc();
    ena = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    n_checks++; if (if3.douta !== 8'h00 || if3.rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rf2: got %h/%b want 00/0", if3.douta, if3.rvalid); end
    n_checks++; if (if0.douta !== 8'h00 || if0.rvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_rf1: got %h/%b want 00/0", if0.douta, if0.rvalid); end
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_checks++; if (if3.rvalid !== 1'b0 || if0.rvalid !== 1'b0) begin
        n_fail++; $display("FAIL midrst_late_rvalid_c%0d: got %b/%b want 0/0", i, if3.rvalid, if0.rvalid);
      end
    end
    n = 0;
    while (if0.busy && n < 100) begin
      cyc();
      n++;
    end
    n_checks++; if (if0.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_ready_timeout: got %b want 0", if0.busy); end
`ifdef SPRAM_RESP_CLEAR_EN
    exp_mem = 8'h00;
`else
    exp_mem = 8'h5E;
`endif
    ena = 1'b1; wea = 1'b0; addra = 5'd4;
    cyc();
    ena = 1'b0;
    cyc();
    n_checks++; if (if0.douta !== exp_mem || if0.rvalid !== 1'b1) begin n_fail++; $display("FAIL midrst_mem: got %h/%b want %h/1", if0.douta, if0.rvalid, exp_mem); end
  endtask

  initial begin
    test_reset();
`ifdef SPRAM_RESP_CLEAR_EN
    test_clear();
`endif
    test_write_read();
    test_collision();
    test_ena_low();
    test_back_to_back();
    test_reset_midstream();
`ifdef SPRAM_RESP_CLEAR_EN
    test_clear_restart();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
